// File: rtl/phase_moderator.sv
// rtl/phase_moderator.sv - parametrised phase sequencer with per-phase divide and strobes
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   en            run enable; low freezes the sequence
//   sync_clr      synchronous restart to phase 0, cycle 0
//   div           requested cycles-per-phase minus 1
//   phase_idx     current phase number
//   phase_onehot  one-hot decode of phase_idx
//   phase_start   first cycle of the current phase
//   phase_last    final cycle of the current phase
//   wrap          final cycle of the last phase
//   tick_tock     phase_idx[0], legacy two-phase toggle

module phase_moderator #(
    parameter int                NUM_PHASES = 2,
    parameter int                CNT_W      = 8,
    parameter logic [CNT_W-1:0]  DIV_RST    = '0,
    parameter int                PHASE_W    = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic [CNT_W-1:0]      div,
    output logic [PHASE_W-1:0]    phase_idx,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  phase_start,
    output logic                  phase_last,
    output logic                  wrap,
    output logic                  tick_tock
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   div_active;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   div_nxt;
    logic [PHASE_W-1:0] idx_nxt;
    logic               at_end;
    logic               in_last_phase;

    // >= rather than == so a divide lowered while frozen ends the phase on
    // the next enabled cycle instead of letting cnt run past div_active.
    assign at_end        = (cnt >= div_active);
    assign in_last_phase = (phase_idx == LAST_PHASE);

    always_comb begin
        cnt_nxt = cnt;
        idx_nxt = phase_idx;
        div_nxt = div_active;
        if (sync_clr) begin
            cnt_nxt = '0;
            idx_nxt = '0;
            div_nxt = div;
        end else if (!en) begin
            // Frozen: the divide register tracks div as a configuration window.
            div_nxt = div;
        end else if (!at_end) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            // Divide ratio is only sampled at a boundary so a phase never
            // changes length part-way through.
            cnt_nxt = '0;
            div_nxt = div;
            idx_nxt = in_last_phase ? '0 : phase_idx + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            phase_idx  <= '0;
            div_active <= DIV_RST;
        end else begin
            cnt        <= cnt_nxt;
            phase_idx  <= idx_nxt;
            div_active <= div_nxt;
        end
    end

    // Strobes are gated by rst_n directly so they drop with reset assertion
    // without waiting for a clock edge.
    always_comb begin
        phase_onehot = NUM_PHASES'(1) << phase_idx;
        tick_tock    = phase_idx[0];
        phase_start  = rst_n & en & (cnt == '0);
        phase_last   = rst_n & en & at_end;
        wrap         = phase_last & in_last_phase;
    end

endmodule

// File: tb/tb_phase_moderator.sv
// tb/tb_phase_moderator.sv - directed self-checking bench for phase_moderator

module tb_phase_moderator;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sync_clr;
    logic [7:0] div;

    logic [0:0] p2_idx;
    logic [1:0] p2_oh;
    logic       p2_start, p2_last, p2_wrap, p2_tt;

    logic [1:0] p3_idx;
    logic [2:0] p3_oh;
    logic       p3_start, p3_last, p3_wrap, p3_tt;

    logic [1:0] p4_idx;
    logic [3:0] p4_oh;
    logic       p4_start, p4_last, p4_wrap, p4_tt;

    int passed = 0;
    int total  = 0;

    phase_moderator #(.NUM_PHASES(2), .CNT_W(8), .DIV_RST(8'd0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .div(div),
        .phase_idx(p2_idx), .phase_onehot(p2_oh), .phase_start(p2_start),
        .phase_last(p2_last), .wrap(p2_wrap), .tick_tock(p2_tt)
    );

    phase_moderator #(.NUM_PHASES(3), .CNT_W(8), .DIV_RST(8'd0)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .div(div),
        .phase_idx(p3_idx), .phase_onehot(p3_oh), .phase_start(p3_start),
        .phase_last(p3_last), .wrap(p3_wrap), .tick_tock(p3_tt)
    );

    phase_moderator #(.NUM_PHASES(4), .CNT_W(8), .DIV_RST(8'd1)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .div(div),
        .phase_idx(p4_idx), .phase_onehot(p4_oh), .phase_start(p4_start),
        .phase_last(p4_last), .wrap(p4_wrap), .tick_tock(p4_tt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] e3_idx [10];
        logic       e3_st  [10];
        logic       e3_ls  [10];
        logic [1:0] em_idx [9];
        logic       em_ls  [9];
        e3_idx = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        e3_st  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        e3_ls  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        em_idx = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        em_ls  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n    = 1'b1;
        en       = 1'b1;
        sync_clr = 1'b0;
        div      = 8'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_idx", 32'(p4_idx), 32'd0);
        chk("rst_oh", 32'(p4_oh), 32'd1);
        chk("rst_tt", 32'(p2_tt), 32'd0);
        chk("rst_start", 32'(p2_start), 32'd0);
        chk("rst_last", 32'(p2_last), 32'd0);
        chk("rst_wrap", 32'(p2_wrap), 32'd0);

        // Legacy two-phase toggle
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("leg_tt[%0d]", c), 32'(p2_tt), 32'((c - 1) % 2));
            chk($sformatf("leg_start[%0d]", c), 32'(p2_start), 32'd1);
            chk($sformatf("leg_last[%0d]", c), 32'(p2_last), 32'd1);
            chk($sformatf("leg_wrap[%0d]", c), 32'(p2_wrap), 32'((c % 2) == 0));
            cyc();
        end

        // Three phases, divide by 3
        en = 1'b0; div = 8'd2; sync_clr = 1'b1;
        cyc();
        en = 1'b1; sync_clr = 1'b0;
        #1;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("p3_idx[%0d]", c), 32'(p3_idx), 32'(e3_idx[c-1]));
            chk($sformatf("p3_start[%0d]", c), 32'(p3_start), 32'(e3_st[c-1]));
            chk($sformatf("p3_last[%0d]", c), 32'(p3_last), 32'(e3_ls[c-1]));
            chk($sformatf("p3_wrap[%0d]", c), 32'(p3_wrap), 32'(c == 9));
            cyc();
        end

        // Mid-phase divide change 3 -> 1
        sync_clr = 1'b1; div = 8'd3; en = 1'b1;
        cyc();
        sync_clr = 1'b0;
        #1;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("mid_idx[%0d]", c), 32'(p4_idx), 32'(em_idx[c-1]));
            chk($sformatf("mid_last[%0d]", c), 32'(p4_last), 32'(em_ls[c-1]));
            if (c == 2) div = 8'd1;
            cyc();
        end

        // Freeze at cnt=4 with div lowered to 2
        sync_clr = 1'b1; div = 8'd5; en = 1'b1;
        cyc();
        sync_clr = 1'b0;
        repeat (4) cyc();
        chk("frz_pre_idx", 32'(p4_idx), 32'd0);
        en = 1'b0; div = 8'd2;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("frz_idx[%0d]", k), 32'(p4_idx), 32'd0);
            chk($sformatf("frz_oh[%0d]", k), 32'(p4_oh), 32'd1);
            chk($sformatf("frz_start[%0d]", k), 32'(p4_start), 32'd0);
            chk($sformatf("frz_last[%0d]", k), 32'(p4_last), 32'd0);
            cyc();
        end
        en = 1'b1;
        #1;
        chk("shr_last", 32'(p4_last), 32'd1);
        chk("shr_start", 32'(p4_start), 32'd0);
        chk("shr_idx", 32'(p4_idx), 32'd0);
        cyc();
        chk("shr_next_idx", 32'(p4_idx), 32'd1);
        chk("shr_next_start", 32'(p4_start), 32'd1);
        chk("shr_next_last", 32'(p4_last), 32'd0);

        // sync_clr mid-phase at phase 2, cnt 1
        sync_clr = 1'b1; div = 8'd1; en = 1'b1;
        cyc();
        sync_clr = 1'b0;
        repeat (5) cyc();
        chk("clr_pre_idx", 32'(p4_idx), 32'd2);
        chk("clr_pre_last", 32'(p4_last), 32'd1);
        sync_clr = 1'b1; div = 8'd0;
        cyc();
        sync_clr = 1'b0;
        #1;
        chk("clr_idx0", 32'(p4_idx), 32'd0);
        chk("clr_start0", 32'(p4_start), 32'd1);
        chk("clr_last0", 32'(p4_last), 32'd1);
        cyc();
        chk("clr_idx1", 32'(p4_idx), 32'd1);
        cyc();
        chk("clr_idx2", 32'(p4_idx), 32'd2);
        chk("clr_wrap2", 32'(p4_wrap), 32'd0);
        cyc();
        chk("clr_idx3", 32'(p4_idx), 32'd3);
        chk("clr_wrap3", 32'(p4_wrap), 32'd1);
        chk("clr_oh3", 32'(p4_oh), 32'h8);
        cyc();
        chk("clr_idx4", 32'(p4_idx), 32'd0);
        cyc();
        chk("clr_idx5", 32'(p4_idx), 32'd1);
        en = 1'b0; sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        #1;
        chk("clr_dis_idx", 32'(p4_idx), 32'd0);
        chk("clr_dis_start", 32'(p4_start), 32'd0);
        en = 1'b1;
        #1;
        chk("clr_en_start", 32'(p4_start), 32'd1);

        // Async reset at phase 1, cnt 2
        sync_clr = 1'b1; div = 8'd3; en = 1'b1;
        cyc();
        sync_clr = 1'b0;
        repeat (6) cyc();
        chk("ar_pre_idx", 32'(p4_idx), 32'd1);
        chk("ar_pre_last", 32'(p4_last), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_idx", 32'(p4_idx), 32'd0);
        chk("ar_oh", 32'(p4_oh), 32'd1);
        chk("ar_tt", 32'(p4_tt), 32'd0);
        chk("ar_start", 32'(p4_start), 32'd0);
        chk("ar_last", 32'(p4_last), 32'd0);
        chk("ar_wrap", 32'(p4_wrap), 32'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("ar_rel_idx", 32'(p4_idx), 32'd0);
        chk("ar_rel_start", 32'(p4_start), 32'd1);
        chk("ar_rel_last", 32'(p4_last), 32'd0);
        cyc();
        chk("ar_c2_idx", 32'(p4_idx), 32'd0);
        chk("ar_c2_last", 32'(p4_last), 32'd1);
        cyc();
        chk("ar_c3_idx", 32'(p4_idx), 32'd1);
        chk("ar_c3_start", 32'(p4_start), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
